// File: rtl/mrna_iso_pkg.sv
// Shared definitions for the mRNA isolation valve sequencer: valve indices,
// the FSM state type, the peristaltic pump pattern and per-step open-valve masks.
package mrna_iso_pkg;

    localparam int NUM_VLV       = 13;

    localparam int VLV_COLLECT   = 0;
    localparam int VLV_LYSIS_IN  = 1;
    localparam int VLV_LYSIS_OUT = 2;
    localparam int VLV_PUSH      = 3;
    localparam int VLV_PUMP1     = 4;
    localparam int VLV_PUMP2     = 5;
    localparam int VLV_PUMP3     = 6;
    localparam int VLV_SEP       = 7;
    localparam int VLV_SIEVE     = 8;
    localparam int VLV_WASTE     = 9;
    localparam int VLV_BEADS     = 10;
    localparam int VLV_CELLS_IN  = 11;
    localparam int VLV_CELLS_OUT = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MIX   = 3'd2,
        ST_SEP   = 3'd3,
        ST_COL   = 3'd4,
        ST_FLUSH = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Pump control values {pump1,pump2,pump3} per phase; 0 = open.
    localparam logic [2:0] PUMP_PAT [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

    // One-hot helper for building open-valve masks.
    function automatic logic [NUM_VLV-1:0] vlv_bit(input int v);
        logic [NUM_VLV-1:0] m;
        m    = '0;
        m[v] = 1'b1;
        return m;
    endfunction

    // Open-valve masks (1 = open); pumps during MIX come from the pump pattern.
    localparam logic [NUM_VLV-1:0] OPEN_LOAD  = vlv_bit(VLV_CELLS_IN) | vlv_bit(VLV_CELLS_OUT) | vlv_bit(VLV_BEADS);
    localparam logic [NUM_VLV-1:0] OPEN_MIX   = vlv_bit(VLV_LYSIS_IN) | vlv_bit(VLV_LYSIS_OUT);
    localparam logic [NUM_VLV-1:0] OPEN_SEP   = vlv_bit(VLV_SEP) | vlv_bit(VLV_SIEVE) | vlv_bit(VLV_WASTE);
    localparam logic [NUM_VLV-1:0] OPEN_COL   = vlv_bit(VLV_PUSH) | vlv_bit(VLV_COLLECT);
    localparam logic [NUM_VLV-1:0] OPEN_FLUSH = '1;

    // Open-valve bits contributed by the pumps for a given phase.
    function automatic logic [NUM_VLV-1:0] pump_open(input logic [2:0] phase);
        logic [2:0]         pat;
        logic [NUM_VLV-1:0] m;
        pat = (phase < 3'd6) ? PUMP_PAT[phase] : 3'b111;
        m   = '0;
        m[VLV_PUMP1] = ~pat[2];
        m[VLV_PUMP2] = ~pat[1];
        m[VLV_PUMP3] = ~pat[0];
        return m;
    endfunction

endpackage

// File: rtl/mrna_iso_valve_sequencer_step_timer.sv
// Step duration down-counter: loading D starts a step lasting max(D,1) cycles;
// expired is high during the last cycle of the step.
module mrna_iso_step_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] dur,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load max(D,1)-1 on step entry, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (dur == '0) ? '0 : dur - CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/mrna_iso_valve_sequencer.sv
// Valve sequencer for an N_CH-channel mRNA isolation bank:
// load -> mix -> separate -> collect -> flush, with per-channel masking.
// Optional flush step selected by macro MRNAISO_SEQ_FLUSH_EN; without it
// COL goes straight to DONE, abort returns to IDLE and flush_o is held at 0.
module mrna_iso_valve_sequencer
    import mrna_iso_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 16,
    parameter int PUMP_DIV  = 4,
    parameter int FLUSH_CYC = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic [CNT_W-1:0]        t_load,
    input  logic [CNT_W-1:0]        t_mix,
    input  logic [CNT_W-1:0]        t_sep,
    input  logic [CNT_W-1:0]        t_col,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [N_CH*NUM_VLV-1:0] ctrl_o,
    output logic [N_CH*NUM_VLV-1:0] flush_o
);

    localparam int              DIV_W    = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PUMP_DIV - 1);

    state_t                  state_q, state_d;
    logic [N_CH-1:0]         mask_q, mask_d;
    logic [CNT_W-1:0]        tmix_q, tmix_d;
    logic [CNT_W-1:0]        tsep_q, tsep_d;
    logic [CNT_W-1:0]        tcol_q, tcol_d;
    logic                    abort_run_q, abort_run_d;
    logic [2:0]              phase_q, phase_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic [N_CH*NUM_VLV-1:0] ctrl_q, ctrl_d;
    logic [N_CH*NUM_VLV-1:0] flush_d;
    logic [NUM_VLV-1:0]      step_open;
    logic                    timer_load;
    logic [CNT_W-1:0]        timer_dur;
    logic                    timer_expired;

    mrna_iso_step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .dur     (timer_dur),
        .expired (timer_expired)
    );

    // Next-state logic: start handshake, timed step advance, abort priority.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        tmix_d      = tmix_q;
        tsep_d      = tsep_q;
        tcol_d      = tcol_q;
        abort_run_d = abort_run_q;
        aborted_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (ch_mask != '0)) begin
                    state_d     = ST_LOAD;
                    mask_d      = ch_mask;
                    tmix_d      = t_mix;
                    tsep_d      = t_sep;
                    tcol_d      = t_col;
                    abort_run_d = 1'b0;
                end
            end
            ST_LOAD, ST_MIX, ST_SEP, ST_COL: begin
                if (abort) begin
                    aborted_d = 1'b1;
`ifdef MRNAISO_SEQ_FLUSH_EN
                    state_d     = ST_FLUSH;
                    abort_run_d = 1'b1;
`else
                    state_d     = ST_IDLE;
`endif
                end else if (timer_expired) begin
                    case (state_q)
                        ST_LOAD: state_d = ST_MIX;
                        ST_MIX:  state_d = ST_SEP;
                        ST_SEP:  state_d = ST_COL;
`ifdef MRNAISO_SEQ_FLUSH_EN
                        default: state_d = ST_FLUSH;
`else
                        default: state_d = ST_DONE;
`endif
                    endcase
                end
            end
            ST_FLUSH: begin
                // An aborted run ends quietly after the flush.
                if (timer_expired) begin
                    state_d = abort_run_q ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Step timer reload on entry to any timed step.
    always_comb begin
        timer_load = (state_d != state_q) && (state_d != ST_IDLE) && (state_d != ST_DONE);
        case (state_d)
            ST_LOAD:  timer_dur = t_load;   // only entered from IDLE, so the live input is the latched value
            ST_MIX:   timer_dur = tmix_d;
            ST_SEP:   timer_dur = tsep_d;
            ST_COL:   timer_dur = tcol_d;
            ST_FLUSH: timer_dur = CNT_W'(FLUSH_CYC);
            default:  timer_dur = '0;
        endcase
    end

    // Pump phase sequencing: restarts on MIX entry, advances every PUMP_DIV cycles.
    always_comb begin
        phase_d = phase_q;
        div_d   = div_q;
        if (state_d == ST_MIX) begin
            if (state_q != ST_MIX) begin
                phase_d = 3'd0;
                div_d   = '0;
            end else if (div_q == DIV_LAST) begin
                div_d   = '0;
                phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
            end else begin
                div_d   = div_q + DIV_W'(1);
            end
        end
    end

    // Output decode from the next state so outputs line up with each step.
    always_comb begin
        case (state_d)
            ST_LOAD:  step_open = OPEN_LOAD;
            ST_MIX:   step_open = OPEN_MIX | pump_open(phase_d);
            ST_SEP:   step_open = OPEN_SEP;
            ST_COL:   step_open = OPEN_COL;
            ST_FLUSH: step_open = OPEN_FLUSH;
            default:  step_open = '0;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Unmasked channels keep every valve closed and never flush.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign ctrl_d[gi*NUM_VLV +: NUM_VLV]  = mask_d[gi] ? ~step_open : '1;
        assign flush_d[gi*NUM_VLV +: NUM_VLV] = (mask_d[gi] && (state_d == ST_FLUSH)) ? '1 : '0;
    end

    // FSM state, latched run parameters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            tmix_q      <= '0;
            tsep_q      <= '0;
            tcol_q      <= '0;
            abort_run_q <= 1'b0;
            phase_q     <= 3'd0;
            div_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            ctrl_q      <= '1;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            tmix_q      <= tmix_d;
            tsep_q      <= tsep_d;
            tcol_q      <= tcol_d;
            abort_run_q <= abort_run_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            ctrl_q      <= ctrl_d;
        end
    end

`ifdef MRNAISO_SEQ_FLUSH_EN
    logic [N_CH*NUM_VLV-1:0] flush_q;

    // Flush-line enable register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= '0;
        end else begin
            flush_q <= flush_d;
        end
    end

    assign flush_o = flush_q;
`else
    logic unused_flush;
    assign unused_flush = ^flush_d;
    assign flush_o      = '0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: tb/tb_mrna_iso_valve_sequencer.sv
// Scoreboard bench for mrna_iso_valve_sequencer: each run's expected per-cycle
// outputs are derived from the step rules and queued; a monitor compares them.
module tb_mrna_iso_valve_sequencer;

    localparam int N_CH      = 4;
    localparam int CNT_W     = 16;
    localparam int PUMP_DIV  = 2;
    localparam int FLUSH_CYC = 4;
    localparam int NV        = 13;
    localparam int W         = N_CH * NV;
`ifdef MRNAISO_SEQ_FLUSH_EN
    localparam bit FLUSH_EN  = 1'b1;
`else
    localparam bit FLUSH_EN  = 1'b0;
`endif

    localparam int S_IDLE = 0, S_LOAD = 1, S_MIX = 2, S_SEP = 3, S_COL = 4, S_FLUSH = 5, S_DONE = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [N_CH-1:0]  ch_mask = '0;
    logic [CNT_W-1:0] t_load = '0, t_mix = '0, t_sep = '0, t_col = '0;
    logic             busy, done, aborted;
    logic [W-1:0]     ctrl_o, flush_o;

    mrna_iso_valve_sequencer #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PUMP_DIV(PUMP_DIV), .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
        .t_load(t_load), .t_mix(t_mix), .t_sep(t_sep), .t_col(t_col),
        .busy(busy), .done(done), .aborted(aborted), .ctrl_o(ctrl_o), .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         busy;
        logic         done;
        logic         aborted;
        logic [W-1:0] ctrl;
        logic [W-1:0] flush;
    } exp_t;

    exp_t     exp_q[$];
    int       checks = 0;
    int       passes = 0;
    int       run_no = 0;
    logic [2:0] pat_tbl [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

    function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    endfunction

    function automatic int max1(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    // Valves open for a step; k is the cycle index within that step.
    function automatic logic [NV-1:0] open_set(input int st, input int k);
        logic [NV-1:0] o;
        logic [2:0]    p;
        o = '0;
        case (st)
            S_LOAD:  begin o[11] = 1'b1; o[12] = 1'b1; o[10] = 1'b1; end
            S_MIX:   begin
                o[1] = 1'b1; o[2] = 1'b1;
                p = pat_tbl[(k / PUMP_DIV) % 6];
                o[4] = ~p[2]; o[5] = ~p[1]; o[6] = ~p[0];
            end
            S_SEP:   begin o[7] = 1'b1; o[8] = 1'b1; o[9] = 1'b1; end
            S_COL:   begin o[3] = 1'b1; o[0] = 1'b1; end
            S_FLUSH: o = '1;
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic exp_t make_exp(input int st, input int k, input logic [N_CH-1:0] m, input bit ab);
        exp_t          e;
        logic [NV-1:0] o;
        o         = open_set(st, k);
        e.busy    = (st != S_IDLE);
        e.done    = (st == S_DONE);
        e.aborted = ab;
        for (int c = 0; c < N_CH; c++) begin
            e.ctrl[c*NV +: NV]  = m[c] ? ~o : {NV{1'b1}};
            e.flush[c*NV +: NV] = (m[c] && st == S_FLUSH) ? {NV{1'b1}} : {NV{1'b0}};
        end
        return e;
    endfunction

    // Reference model: expand the protocol into a per-cycle step list, cut it at a taken abort.
    function automatic void build(input logic [N_CH-1:0] m, input int tl, input int tm,
                                  input int ts, input int tc, input int abort_at);
        int steps[$];
        int idx[$];
        int order[$];
        int lens[7];
        int ab_cyc;
        ab_cyc = -1;
        if (m == '0) begin
            for (int i = 0; i < 3; i++) exp_q.push_back(make_exp(S_IDLE, 0, m, 1'b0));
            return;
        end
        lens[S_LOAD] = max1(tl); lens[S_MIX] = max1(tm); lens[S_SEP] = max1(ts);
        lens[S_COL] = max1(tc); lens[S_FLUSH] = FLUSH_CYC; lens[S_DONE] = 1; lens[S_IDLE] = 1;
        order = '{S_LOAD, S_MIX, S_SEP, S_COL};
        if (FLUSH_EN) order.push_back(S_FLUSH);
        order.push_back(S_DONE);
        foreach (order[j])
            for (int k = 0; k < lens[order[j]]; k++) begin
                steps.push_back(order[j]);
                idx.push_back(k);
            end
        if (abort_at >= 0 && abort_at < steps.size() &&
            steps[abort_at] >= S_LOAD && steps[abort_at] <= S_COL) begin
            while (steps.size() > abort_at + 1) begin
                void'(steps.pop_back());
                void'(idx.pop_back());
            end
            ab_cyc = abort_at + 1;
            if (FLUSH_EN) begin
                for (int k = 0; k < FLUSH_CYC; k++) begin
                    steps.push_back(S_FLUSH);
                    idx.push_back(k);
                end
            end else begin
                steps.push_back(S_IDLE);
                idx.push_back(0);
            end
        end
        steps.push_back(S_IDLE);
        idx.push_back(0);
        foreach (steps[i]) exp_q.push_back(make_exp(steps[i], idx[i], m, (i == ab_cyc)));
    endfunction

    // Monitor: pop one expected record per cycle and compare.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("busy",    W'(busy),    W'(e.busy));
            chk("done",    W'(done),    W'(e.done));
            chk("aborted", W'(aborted), W'(e.aborted));
            chk("ctrl_o",  ctrl_o,      e.ctrl);
            chk("flush_o", flush_o,     e.flush);
        end
    end

    task automatic run(input logic [N_CH-1:0] m, input int tl, input int tm, input int ts,
                       input int tc, input int abort_at, input bit extra_start, input int rst_at);
        int n;
        int es;
        int busy_idx[$];
        run_no++;
        @(posedge clk); #1;
        start = 1'b1; ch_mask = m;
        t_load = CNT_W'(tl); t_mix = CNT_W'(tm); t_sep = CNT_W'(ts); t_col = CNT_W'(tc);
        @(posedge clk);
        build(m, tl, tm, ts, tc, abort_at);
        n  = exp_q.size();
        es = -1;
        if (extra_start) begin
            foreach (exp_q[i]) if (exp_q[i].busy) busy_idx.push_back(i);
            if (busy_idx.size() != 0) es = busy_idx[$urandom_range(0, busy_idx.size() - 1)];
        end
        $display("run %0d mask=%b t=%0d/%0d/%0d/%0d abort_at=%0d extra_start_at=%0d rst_at=%0d",
                 run_no, m, tl, tm, ts, tc, abort_at, es, rst_at);
        #1;
        start = 1'b0;
        t_load = CNT_W'($urandom); t_mix = CNT_W'($urandom);
        t_sep = CNT_W'($urandom);  t_col = CNT_W'($urandom);
        for (int i = 0; i < n; i++) begin
            abort = (i == abort_at);
            start = (i == es);
            if (i == es) ch_mask = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            if (i == rst_at) begin
                #2 rst = 1'b1;
                exp_q.delete();
                #1;
                chk("rst_ctrl",    ctrl_o,            {W{1'b1}});
                chk("rst_flush",   flush_o,           {W{1'b0}});
                chk("rst_busy",    W'(busy),          W'(0));
                chk("rst_done",    W'(done),          W'(0));
                chk("rst_aborted", W'(aborted),       W'(0));
                @(posedge clk); #1;
                rst = 1'b0; abort = 1'b0; start = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [N_CH-1:0] m;
        int ab;
        #2 rst = 1'b1;
        #1;
        chk("reset_ctrl",  ctrl_o,   {W{1'b1}});
        chk("reset_flush", flush_o,  {W{1'b0}});
        chk("reset_busy",  W'(busy), W'(0));
        chk("reset_done",  W'(done), W'(0));
        chk("reset_abort", W'(aborted), W'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run(4'b0101, 3, 12, 2, 2, -1, 1'b0, -1);      // nominal run with pump pattern
        run(4'b0001, 0, 0, 0, 0, -1, 1'b0, -1);       // zero durations
        run(4'b0101, 3, 12, 2, 2, 3 + 5, 1'b0, -1);   // abort 5 cycles into MIX
        run(4'b0000, 3, 3, 3, 3, -1, 1'b0, -1);       // start with empty mask ignored
        run(4'b1010, 2, 4, 2, 2, -1, 1'b1, -1);       // second start while busy ignored
        run(4'b1111, 2, 3, 4, 2, -1, 1'b0, 2 + 3 + 1); // reset mid-SEP
        run(4'b0101, 3, 12, 2, 2, -1, 1'b0, -1);      // normal run after reset
        run(4'b0011, 1, 2, 1, 1, 1 + 2 + 1 + 0, 1'b0, -1); // abort in COL (its only cycle)
        run(4'b1001, 1, 1, 1, 1, 5, 1'b0, -1);        // abort in FLUSH/DONE region ignored

        for (int r = 0; r < 25; r++) begin
            m  = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            ab = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 25));
            run(m, $urandom_range(0, 6), $urandom_range(0, 14), $urandom_range(0, 6),
                $urandom_range(0, 6), ab, 1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
